// File: rtl/sdram_arbiter_pkg.sv
// Shared types for the SDRAM arbiter: grant states, read-tag encoding and
// the SDRAM word-address width.
package sdram_arbiter_pkg;

  localparam int SDRAM_ADDR_W = 26;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic TAG_I = 1'b0;
  localparam logic TAG_D = 1'b1;

endpackage

// File: rtl/sdram_tag_fifo.sv
// Ordered FIFO of 1-bit owner tags for SDRAM reads still waiting on rdvalid.
// Pops on an empty FIFO are ignored; a push into a full FIFO is only taken with a pop.
module sdram_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] r_tags;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == (PTR_W+1)'(DEPTH));
  assign dout     = r_tags[r_rdPtr];
  assign w_doPop  = pop & ~empty;
  assign w_doPush = push & (~full | w_doPop);

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_doPush) r_tags[r_wrPtr] <= din;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between I-cache and D-cache,
// routing in-order read returns back to their owner through a tag FIFO.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int TAG_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    icache_sdram_request,
  input  logic [SDRAM_ADDR_W-1:0] icache_sdram_addr,
  output logic                    icache_sdram_ack,
  output logic [31:0]             icache_sdram_rdata,
  output logic                    icache_sdram_rdvalid,
  input  logic                    dcache_sdram_request,
  input  logic [SDRAM_ADDR_W-1:0] dcache_sdram_addr,
  input  logic                    dcache_sdram_write,
  input  logic [3:0]              dcache_sdram_byte_enable,
  input  logic [31:0]             dcache_sdram_wdata,
  output logic                    dcache_sdram_ack,
  output logic [31:0]             dcache_sdram_rdata,
  output logic                    dcache_sdram_rdvalid,
  output logic                    sdram_request,
  output logic [SDRAM_ADDR_W-1:0] sdram_addr,
  output logic                    sdram_write,
  output logic [3:0]              sdram_byte_enable,
  output logic [31:0]             sdram_wdata,
  input  logic                    sdram_ack,
  input  logic [31:0]             sdram_rdata,
  input  logic                    sdram_rdvalid,
  output logic                    arb_error
);

  state_t r_state;
  state_t w_nextState;
  logic   r_lastGrant;
  logic   r_arbError;

  logic                    w_fifoFull;
  logic                    w_fifoEmpty;
  logic                    w_fifoHead;
  logic                    w_push;
  logic                    w_pushTag;
  logic                    w_iEligible;
  logic                    w_dEligible;
  logic                    w_req;
  logic [SDRAM_ADDR_W-1:0] w_addr;
  logic                    w_write;
  logic [3:0]              w_byteEnable;
  logic [31:0]             w_wdata;
  logic                    w_ackI;
  logic                    w_ackD;
  logic                    w_rdvalidI;
  logic                    w_rdvalidD;

  // A read needs a free tag slot; a write never returns data so it always may go.
  assign w_iEligible = icache_sdram_request & ~w_fifoFull;
  assign w_dEligible = dcache_sdram_request & (dcache_sdram_write | ~w_fifoFull);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lastGrant <= TAG_D;
      r_arbError  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == GRANT_I && sdram_ack) r_lastGrant <= TAG_I;
      else if (r_state == GRANT_D && sdram_ack) r_lastGrant <= TAG_D;
      if ((r_state == IDLE && sdram_ack) || (sdram_rdvalid && w_fifoEmpty))
        r_arbError <= 1'b1;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_req        = 1'b0;
    w_addr       = '0;
    w_write      = 1'b0;
    w_byteEnable = 4'h0;
    w_wdata      = '0;
    w_ackI       = 1'b0;
    w_ackD       = 1'b0;
    w_push       = 1'b0;
    w_pushTag    = TAG_I;
    case (r_state)
      IDLE: begin
        if (w_iEligible && w_dEligible)
          w_nextState = (r_lastGrant == TAG_D) ? GRANT_I : GRANT_D;
        else if (w_iEligible)
          w_nextState = GRANT_I;
        else if (w_dEligible)
          w_nextState = GRANT_D;
      end
      GRANT_I: begin
        w_req        = 1'b1;
        w_addr       = icache_sdram_addr;
        w_byteEnable = 4'hF;
        w_ackI       = sdram_ack;
        w_push       = sdram_ack;
        w_pushTag    = TAG_I;
        if (sdram_ack) w_nextState = IDLE;
      end
      GRANT_D: begin
        w_req        = 1'b1;
        w_addr       = dcache_sdram_addr;
        w_write      = dcache_sdram_write;
        w_byteEnable = dcache_sdram_byte_enable;
        w_wdata      = dcache_sdram_wdata;
        w_ackD       = sdram_ack;
        w_push       = sdram_ack & ~dcache_sdram_write;
        w_pushTag    = TAG_D;
        if (sdram_ack) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  sdram_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tagFifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (sdram_rdvalid),
    .din   (w_pushTag),
    .dout  (w_fifoHead),
    .full  (w_fifoFull),
    .empty (w_fifoEmpty)
  );

  assign w_rdvalidI = sdram_rdvalid & ~w_fifoEmpty & (w_fifoHead == TAG_I);
  assign w_rdvalidD = sdram_rdvalid & ~w_fifoEmpty & (w_fifoHead == TAG_D);

  // Every output is forced low for as long as reset is held.
  assign sdram_request        = reset ? 1'b0 : w_req;
  assign sdram_addr           = reset ? '0   : w_addr;
  assign sdram_write          = reset ? 1'b0 : w_write;
  assign sdram_byte_enable    = reset ? 4'h0 : w_byteEnable;
  assign sdram_wdata          = reset ? '0   : w_wdata;
  assign icache_sdram_ack     = reset ? 1'b0 : w_ackI;
  assign dcache_sdram_ack     = reset ? 1'b0 : w_ackD;
  assign icache_sdram_rdvalid = reset ? 1'b0 : w_rdvalidI;
  assign dcache_sdram_rdvalid = reset ? 1'b0 : w_rdvalidD;
  assign icache_sdram_rdata   = reset ? '0   : sdram_rdata;
  assign dcache_sdram_rdata   = reset ? '0   : sdram_rdata;
  assign arb_error            = r_arbError & ~reset;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: a queue-based grant/tag model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_sdram_arbiter;

  localparam int TAG_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        icache_sdram_request;
  logic [25:0] icache_sdram_addr;
  logic        icache_sdram_ack;
  logic [31:0] icache_sdram_rdata;
  logic        icache_sdram_rdvalid;
  logic        dcache_sdram_request;
  logic [25:0] dcache_sdram_addr;
  logic        dcache_sdram_write;
  logic [3:0]  dcache_sdram_byte_enable;
  logic [31:0] dcache_sdram_wdata;
  logic        dcache_sdram_ack;
  logic [31:0] dcache_sdram_rdata;
  logic        dcache_sdram_rdvalid;
  logic        sdram_request;
  logic [25:0] sdram_addr;
  logic        sdram_write;
  logic [3:0]  sdram_byte_enable;
  logic [31:0] sdram_wdata;
  logic        sdram_ack;
  logic [31:0] sdram_rdata;
  logic        sdram_rdvalid;
  logic        arb_error;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;

  logic        sReq, sWrite, sAckI, sAckD, sRvI, sRvD, sErr;
  logic [25:0] sAddr;
  logic [3:0]  sBe;
  logic [31:0] sWdata, sRdataI, sRdataD;

  sdram_arbiter #(.TAG_DEPTH(TAG_DEPTH)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .icache_sdram_request     (icache_sdram_request),
    .icache_sdram_addr        (icache_sdram_addr),
    .icache_sdram_ack         (icache_sdram_ack),
    .icache_sdram_rdata       (icache_sdram_rdata),
    .icache_sdram_rdvalid     (icache_sdram_rdvalid),
    .dcache_sdram_request     (dcache_sdram_request),
    .dcache_sdram_addr        (dcache_sdram_addr),
    .dcache_sdram_write       (dcache_sdram_write),
    .dcache_sdram_byte_enable (dcache_sdram_byte_enable),
    .dcache_sdram_wdata       (dcache_sdram_wdata),
    .dcache_sdram_ack         (dcache_sdram_ack),
    .dcache_sdram_rdata       (dcache_sdram_rdata),
    .dcache_sdram_rdvalid     (dcache_sdram_rdvalid),
    .sdram_request            (sdram_request),
    .sdram_addr               (sdram_addr),
    .sdram_write              (sdram_write),
    .sdram_byte_enable        (sdram_byte_enable),
    .sdram_wdata              (sdram_wdata),
    .sdram_ack                (sdram_ack),
    .sdram_rdata              (sdram_rdata),
    .sdram_rdvalid            (sdram_rdvalid),
    .arb_error                (arb_error)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  // Reference model: who holds the grant (0 none, 1 I, 2 D), who won last,
  // the queue of owners for reads in flight, and the sticky error.
  int   mGrant = 0;
  bit   mLastWasI = 1'b0;
  bit   mTags[$];
  bit   mErr = 1'b0;

  always @(negedge clock) begin
    logic        eReq, eWrite, eAckI, eAckD, eRvI, eRvD, eErr;
    logic [25:0] eAddr;
    logic [3:0]  eBe;
    logic [31:0] eWdata, eRdata;
    bit          full, iOk, dOk;

    full   = (mTags.size() >= TAG_DEPTH);
    eReq   = 1'b0; eWrite = 1'b0; eAddr = '0; eBe = '0; eWdata = '0;
    eAckI  = 1'b0; eAckD = 1'b0; eRvI = 1'b0; eRvD = 1'b0;
    eRdata = reset ? 32'h0 : sdram_rdata;
    eErr   = reset ? 1'b0 : mErr;
    if (!reset) begin
      if (mGrant == 1) begin
        eReq = 1'b1; eAddr = icache_sdram_addr; eBe = 4'hF; eAckI = sdram_ack;
      end else if (mGrant == 2) begin
        eReq = 1'b1; eAddr = dcache_sdram_addr; eWrite = dcache_sdram_write;
        eBe = dcache_sdram_byte_enable; eWdata = dcache_sdram_wdata; eAckD = sdram_ack;
      end
      if (sdram_rdvalid && mTags.size() > 0) begin
        if (mTags[0] == 1'b0) eRvI = 1'b1;
        else eRvD = 1'b1;
      end
    end

    checkOutput("sdram_request", 64'(sdram_request), 64'(eReq));
    checkOutput("sdram_addr", 64'(sdram_addr), 64'(eAddr));
    checkOutput("sdram_write", 64'(sdram_write), 64'(eWrite));
    checkOutput("sdram_byte_enable", 64'(sdram_byte_enable), 64'(eBe));
    checkOutput("sdram_wdata", 64'(sdram_wdata), 64'(eWdata));
    checkOutput("icache_ack", 64'(icache_sdram_ack), 64'(eAckI));
    checkOutput("dcache_ack", 64'(dcache_sdram_ack), 64'(eAckD));
    checkOutput("icache_rdvalid", 64'(icache_sdram_rdvalid), 64'(eRvI));
    checkOutput("dcache_rdvalid", 64'(dcache_sdram_rdvalid), 64'(eRvD));
    checkOutput("icache_rdata", 64'(icache_sdram_rdata), 64'(eRdata));
    checkOutput("dcache_rdata", 64'(dcache_sdram_rdata), 64'(eRdata));
    checkOutput("arb_error", 64'(arb_error), 64'(eErr));

    if (reset) begin
      mGrant = 0; mLastWasI = 1'b0; mTags.delete(); mErr = 1'b0;
    end else begin
      if ((mGrant == 0 && sdram_ack) || (sdram_rdvalid && mTags.size() == 0)) mErr = 1'b1;
      if (sdram_rdvalid && mTags.size() > 0) void'(mTags.pop_front());
      if (mGrant == 1 && sdram_ack) begin
        mTags.push_back(1'b0); mLastWasI = 1'b1; mGrant = 0;
      end else if (mGrant == 2 && sdram_ack) begin
        if (!dcache_sdram_write) mTags.push_back(1'b1);
        mLastWasI = 1'b0; mGrant = 0;
      end else if (mGrant == 0) begin
        iOk = icache_sdram_request && !full;
        dOk = dcache_sdram_request && (dcache_sdram_write || !full);
        if (iOk && dOk) mGrant = mLastWasI ? 2 : 1;
        else if (iOk) mGrant = 1;
        else if (dOk) mGrant = 2;
      end
    end
  end

  // One bench cycle: sample mid-cycle, then step past the edge; masters drop
  // their request after being acked and the controller strobes are one-shot.
  task automatic cycle();
    @(negedge clock);
    sReq = sdram_request; sWrite = sdram_write; sAddr = sdram_addr;
    sBe = sdram_byte_enable; sWdata = sdram_wdata;
    sAckI = icache_sdram_ack; sAckD = dcache_sdram_ack;
    sRvI = icache_sdram_rdvalid; sRvD = dcache_sdram_rdvalid;
    sRdataI = icache_sdram_rdata; sRdataD = dcache_sdram_rdata; sErr = arb_error;
    @(posedge clock);
    #1;
    cycleNo++;
    if (sAckI) icache_sdram_request = 1'b0;
    if (sAckD) dcache_sdram_request = 1'b0;
    sdram_ack = 1'b0;
    sdram_rdvalid = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    icache_sdram_request = 1'b0; icache_sdram_addr = '0;
    dcache_sdram_request = 1'b0; dcache_sdram_addr = '0; dcache_sdram_write = 1'b0;
    dcache_sdram_byte_enable = 4'h0; dcache_sdram_wdata = '0;
    sdram_ack = 1'b0; sdram_rdvalid = 1'b0; sdram_rdata = 32'hA5A5_A5A5;
    cycle();
    cycle();
    checkOutput("reset rdata gated", 64'(sRdataI), 64'h0);
    checkOutput("reset request", 64'(sReq), 64'h0);
    checkOutput("reset error", 64'(sErr), 64'h0);
    reset = 1'b0;
    sdram_rdata = '0;
  endtask

  task automatic serve(input int waitCycles);
    int n = 0;
    while (!sdram_request && n < 20) begin
      cycle();
      n++;
    end
    checkOutput("grant within budget", 64'(sdram_request), 64'h1);
    repeat (waitCycles) cycle();
    sdram_ack = 1'b1;
    cycle();
  endtask

  task automatic returnRead(input logic [31:0] data);
    sdram_rdvalid = 1'b1;
    sdram_rdata = data;
    cycle();
  endtask

  task automatic applyStimulus();
    // Single I-side read with latency, ack and data return.
    applyReset();
    icache_sdram_request = 1'b1; icache_sdram_addr = 26'h0000123;
    cycle();
    checkOutput("i latency idle", 64'(sReq), 64'h0);
    cycle();
    checkOutput("i latency grant", 64'(sReq), 64'h1);
    checkOutput("i addr", 64'(sAddr), 64'h123);
    checkOutput("i byte enable", 64'(sBe), 64'hF);
    cycle();
    sdram_ack = 1'b1;
    cycle();
    checkOutput("i ack", 64'(sAckI), 64'h1);
    checkOutput("d ack silent", 64'(sAckD), 64'h0);
    cycle();
    cycle();
    returnRead(32'hDEADBEEF);
    checkOutput("i rdvalid", 64'(sRvI), 64'h1);
    checkOutput("d rdvalid silent", 64'(sRvD), 64'h0);
    checkOutput("i rdata", 64'(sRdataI), 64'hDEADBEEF);

    // Tie from reset: I first, D two cycles after, then D beats re-requesting I.
    applyReset();
    icache_sdram_request = 1'b1; icache_sdram_addr = 26'h10;
    dcache_sdram_request = 1'b1; dcache_sdram_addr = 26'h20;
    dcache_sdram_write = 1'b0; dcache_sdram_byte_enable = 4'hF;
    cycle();
    sdram_ack = 1'b1;
    cycle();
    checkOutput("tie first ack I", 64'(sAckI), 64'h1);
    checkOutput("tie first not D", 64'(sAckD), 64'h0);
    icache_sdram_request = 1'b1; icache_sdram_addr = 26'h11;
    cycle();
    checkOutput("bubble after ack", 64'(sReq), 64'h0);
    sdram_ack = 1'b1;
    cycle();
    checkOutput("round robin D", 64'(sAckD), 64'h1);
    checkOutput("round robin addr", 64'(sAddr), 64'h20);
    cycle();
    sdram_ack = 1'b1;
    cycle();
    checkOutput("then I", 64'(sAckI), 64'h1);
    returnRead(32'h1);
    checkOutput("order 1 to I", 64'(sRvI), 64'h1);
    returnRead(32'h2);
    checkOutput("order 2 to D", 64'(sRvD), 64'h1);
    checkOutput("order 2 data", 64'(sRdataD), 64'h2);
    returnRead(32'h3);
    checkOutput("order 3 to I", 64'(sRvI), 64'h1);

    // D-side write passes fields through and leaves no tag behind.
    dcache_sdram_request = 1'b1; dcache_sdram_write = 1'b1;
    dcache_sdram_addr = 26'h0001000; dcache_sdram_byte_enable = 4'b0011;
    dcache_sdram_wdata = 32'h12345678;
    cycle();
    sdram_ack = 1'b1;
    cycle();
    checkOutput("write ack", 64'(sAckD), 64'h1);
    checkOutput("write flag", 64'(sWrite), 64'h1);
    checkOutput("write addr", 64'(sAddr), 64'h0001000);
    checkOutput("write be", 64'(sBe), 64'h3);
    checkOutput("write data", 64'(sWdata), 64'h12345678);

    // Fill the tag FIFO, then a read must wait while a write still goes.
    for (int k = 0; k < TAG_DEPTH; k++) begin
      icache_sdram_request = 1'b1; icache_sdram_addr = 26'h100 + 26'(k);
      serve(0);
    end
    icache_sdram_request = 1'b1; icache_sdram_addr = 26'h200;
    repeat (3) begin
      cycle();
      checkOutput("full read held", 64'(sReq), 64'h0);
    end
    dcache_sdram_request = 1'b1; dcache_sdram_write = 1'b1;
    dcache_sdram_addr = 26'h300; dcache_sdram_byte_enable = 4'hF; dcache_sdram_wdata = 32'hCAFE;
    cycle();
    sdram_ack = 1'b1;
    cycle();
    checkOutput("write while full", 64'(sAckD), 64'h1);
    returnRead(32'h55);
    checkOutput("pop while full", 64'(sRvI), 64'h1);
    cycle();
    checkOutput("regrant idle", 64'(sReq), 64'h0);
    sdram_ack = 1'b1;
    cycle();
    checkOutput("held read granted", 64'(sAckI), 64'h1);
    checkOutput("held read addr", 64'(sAddr), 64'h200);
    for (int k = 0; k < TAG_DEPTH; k++) begin
      returnRead(32'h60 + 32'(k));
      checkOutput("drain to I", 64'(sRvI), 64'h1);
    end

    // Protocol errors: rdvalid with nothing outstanding, ack while idle.
    returnRead(32'h77);
    checkOutput("empty rdvalid I", 64'(sRvI), 64'h0);
    checkOutput("empty rdvalid D", 64'(sRvD), 64'h0);
    cycle();
    checkOutput("empty rdvalid error", 64'(sErr), 64'h1);
    applyReset();
    sdram_ack = 1'b1;
    cycle();
    checkOutput("idle ack no I ack", 64'(sAckI), 64'h0);
    checkOutput("idle ack no D ack", 64'(sAckD), 64'h0);
    cycle();
    checkOutput("idle ack error", 64'(sErr), 64'h1);

    // Reset during GRANT_D with a read outstanding drops both.
    applyReset();
    icache_sdram_request = 1'b1; icache_sdram_addr = 26'h7;
    serve(0);
    dcache_sdram_request = 1'b1; dcache_sdram_write = 1'b0; dcache_sdram_addr = 26'h40;
    cycle();
    cycle();
    checkOutput("in GRANT_D", 64'(sReq), 64'h1);
    reset = 1'b1;
    sdram_ack = 1'b1;
    cycle();
    checkOutput("reset kills request", 64'(sReq), 64'h0);
    checkOutput("reset kills ack", 64'(sAckD), 64'h0);
    reset = 1'b0;
    dcache_sdram_request = 1'b0;
    cycle();
    checkOutput("idle after reset", 64'(sReq), 64'h0);
    checkOutput("error clear after reset", 64'(sErr), 64'h0);
    returnRead(32'h88);
    checkOutput("abandoned tag I", 64'(sRvI), 64'h0);
    checkOutput("abandoned tag D", 64'(sRvD), 64'h0);
    cycle();
    checkOutput("abandoned tag error", 64'(sErr), 64'h1);
  endtask

  initial begin
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: bench did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter TAG_DEPTH, default 4, meaning max outstanding SDRAM reads awaiting rdvalid (power of 2, >=2).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 icache_sdram_request  input  1  I-side request, held until icache_sdram_ack.
REQ-005 icache_sdram_addr  input  26  I-side word address; I-side is read-only.
REQ-006 icache_sdram_ack  output  1  I-side request accepted, one-cycle pulse.
REQ-007 icache_sdram_rdata  output  32  read data; icache_sdram_rdvalid  output  1  I-side read data valid.
REQ-008 dcache_sdram_request / _addr[25:0] / _write / _byte_enable[3:0] / _wdata[31:0]  inputs  D-side request, held until dcache_sdram_ack.
REQ-009 dcache_sdram_ack, dcache_sdram_rdvalid  output  1 each; dcache_sdram_rdata  output  32.
REQ-010 sdram_request / _addr[25:0] / _write / _byte_enable[3:0] / _wdata[31:0]  outputs  toward SDRAM controller.
REQ-011 sdram_ack  input  1  controller accepted request; sdram_rdata  input  32; sdram_rdvalid  input  1.
REQ-012 arb_error  output  1  sticky protocol-error flag.

Function
REQ-013 States IDLE, GRANT_I, GRANT_D; state register plus last_grant bit (I or D).
REQ-014 IDLE: only one side requesting and eligible -> grant it; both -> grant side opposite last_grant; none -> stay IDLE.
REQ-015 Eligibility: I-side always a read; D-side read iff dcache_sdram_write=0; a read is ineligible while tag FIFO full; writes are always eligible.
REQ-016 GRANT_x: sdram_request=1, sdram_* fields driven combinationally from granted master (I-side: write=0, byte_enable=4'hF, wdata=0); stays until sdram_ack.
REQ-017 sdram_ack in GRANT_x: x_sdram_ack=1 same cycle (combinational), last_grant<=x, next state IDLE; earliest re-grant is the following cycle (one bubble).
REQ-018 Outside GRANT states sdram_request=0 and both acks 0; sdram_ack in IDLE sets arb_error.
REQ-019 Latency: master request first high in cycle N -> sdram_request high in cycle N+1.
REQ-020 Tag FIFO (TAG_DEPTH entries, 1-bit tag I/D): push granted tag on sdram_ack when the granted access is a read.
REQ-021 sdram_rdvalid pops FIFO head; head=I -> icache_sdram_rdvalid=1, head=D -> dcache_sdram_rdvalid=1, same cycle (combinational).
REQ-022 sdram_rdata broadcast to both rdata outputs unchanged.
REQ-023 Simultaneous push and pop: both occur, count unchanged, legal even when full.
REQ-024 sdram_rdvalid with FIFO empty: no rdvalid to either master, arb_error set, count stays 0.
REQ-025 Pointers wrap modulo TAG_DEPTH; count width clog2(TAG_DEPTH)+1.
REQ-026 Read order preserved: controller returns reads in issue order; FIFO relies on it.

Reset
REQ-027 reset: state=IDLE, last_grant=D (I wins first tie), FIFO count=0, pointers=0, arb_error=0.
REQ-028 Reset mid-transaction abandons grant and outstanding tags; later rdvalid with empty FIFO flags arb_error.
REQ-029 All outputs 0 while reset high.

Structure
REQ-030 Shared package holds state enum (IDLE, GRANT_I, GRANT_D), tag encoding (TAG_I=0, TAG_D=1), SDRAM address width 26.
REQ-031 Tag FIFO is one sub-module, sdram_tag_fifo (push, pop, din, dout, full, empty).

Verification
REQ-032 I read only, ack after 2 cycles, rdvalid 3 cycles later -> icache_sdram_ack 1 cycle, icache_sdram_rdvalid with rdata 32'hDEADBEEF, D-side silent.
REQ-033 I and D both request from reset, cycle 0 -> I granted first, D granted 2 cycles after I ack; then both again -> D wins (round-robin).
REQ-034 D write addr 26'h0001000 be 4'b0011 wdata 32'h12345678 -> sdram fields match, dcache ack, no FIFO push, no rdvalid.
REQ-035 TAG_DEPTH=4: issue 4 reads without rdvalid -> 5th read held, D write still granted; one rdvalid -> 5th read granted next IDLE.
REQ-036 Interleaved I,D,I reads then 3 rdvalids -> rdvalid routed I,D,I in order.
REQ-037 rdvalid with empty FIFO, and reset asserted during GRANT_D -> arb_error=1, state IDLE after reset, no spurious acks.
